// File: rtl/cic_decimator.sv
// N-stage Hogenauer CIC decimator (M = 1) with runtime power-of-two rate and
// gain-normalised output taken as a truncated bit window of the last comb.
module cic_decimator #(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned MAX_RATE_LOG2 = 6
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic [$clog2(MAX_RATE_LOG2+1)-1:0]   i_rate_log2,
  input  logic                                 i_cfg_load,
  input  logic signed [IN_WIDTH-1:0]           i_in_data,
  input  logic                                 i_in_valid,
  output logic signed [OUT_WIDTH-1:0]          o_out_data,
  output logic                                 o_out_valid,
  output logic [$clog2(MAX_RATE_LOG2+1)-1:0]   o_rate_log2
);

  localparam int unsigned ACC_WIDTH = IN_WIDTH + NUM_STAGES * MAX_RATE_LOG2;
  localparam int unsigned RATE_W    = $clog2(MAX_RATE_LOG2 + 1);
  localparam int unsigned CNT_W     = MAX_RATE_LOG2;
  localparam int unsigned G_W       = $clog2(ACC_WIDTH + 1);
  localparam int unsigned EXT_W     = ACC_WIDTH + OUT_WIDTH;

  logic [RATE_W-1:0]                rate_q, rate_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             dec_q, dec_d;
  logic signed [ACC_WIDTH-1:0]      integ_q [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0]      integ_d [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0]      comb_q  [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0]      comb_d  [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0]      dly_q   [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0]      dly_d   [NUM_STAGES];
  logic [NUM_STAGES-1:0]            comb_v_q, comb_v_d;
  logic signed [OUT_WIDTH-1:0]      out_data_q, out_data_d;
  logic                             out_valid_q, out_valid_d;

  logic [RATE_W-1:0]                rate_clamp_c;
  logic [CNT_W:0]                   span_c;
  logic                             edge_c;
  logic signed [ACC_WIDTH-1:0]      x_ext_c;
  logic [G_W-1:0]                   gain_log2_c;
  logic [EXT_W-1:0]                 scale_ext_c;
  logic [EXT_W-1:0]                 scale_shift_c;

  // Rate clamp, decimation edge detect and output bit-window selection
  always_comb begin
    rate_clamp_c = (i_rate_log2 > RATE_W'(MAX_RATE_LOG2)) ? RATE_W'(MAX_RATE_LOG2) : i_rate_log2;
    span_c       = ((CNT_W+1)'(1) << rate_q) - (CNT_W+1)'(1);
    edge_c       = i_in_valid && (cnt_q == span_c[CNT_W-1:0]);
    x_ext_c      = {{(ACC_WIDTH-IN_WIDTH){i_in_data[IN_WIDTH-1]}}, i_in_data};
    gain_log2_c  = G_W'(IN_WIDTH) + G_W'(NUM_STAGES) * G_W'(rate_q);
    // Appending OUT_WIDTH zeros lets short windows zero-fill their low bits
    scale_ext_c   = {comb_q[NUM_STAGES-1], {OUT_WIDTH{1'b0}}};
    scale_shift_c = scale_ext_c >> gain_log2_c;
  end

  // Next-state: integrators on valid input, combs on decimated samples
  always_comb begin
    rate_d      = rate_q;
    cnt_d       = cnt_q;
    dec_d       = 1'b0;
    integ_d     = integ_q;
    comb_d      = comb_q;
    dly_d       = dly_q;
    comb_v_d    = '0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    if (i_reset || i_cfg_load) begin
      rate_d     = rate_clamp_c;
      cnt_d      = '0;
      integ_d    = '{default: '0};
      comb_d     = '{default: '0};
      dly_d      = '{default: '0};
      out_data_d = '0;
    end else begin
      if (i_in_valid) begin
        integ_d[0] = integ_q[0] + x_ext_c;
        for (int s = 1; s < NUM_STAGES; s++) begin
          integ_d[s] = integ_q[s] + integ_q[s-1];
        end
        cnt_d = edge_c ? '0 : cnt_q + CNT_W'(1);
      end
      dec_d = edge_c;

      comb_v_d[0] = dec_q;
      if (dec_q) begin
        comb_d[0] = integ_q[NUM_STAGES-1] - dly_q[0];
        dly_d[0]  = integ_q[NUM_STAGES-1];
      end
      for (int s = 1; s < NUM_STAGES; s++) begin
        comb_v_d[s] = comb_v_q[s-1];
        if (comb_v_q[s-1]) begin
          comb_d[s] = comb_q[s-1] - dly_q[s];
          dly_d[s]  = comb_q[s-1];
        end
      end

      out_valid_d = comb_v_q[NUM_STAGES-1];
      if (comb_v_q[NUM_STAGES-1]) begin
        out_data_d = scale_shift_c[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    rate_q      <= rate_d;
    cnt_q       <= cnt_d;
    dec_q       <= dec_d;
    integ_q     <= integ_d;
    comb_q      <= comb_d;
    dly_q       <= dly_d;
    comb_v_q    <= comb_v_d;
    out_data_q  <= out_data_d;
    out_valid_q <= out_valid_d;
  end

  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_rate_log2 = rate_q;

endmodule
